// File: rtl/mem_request_initiator.sv
// Word-memory request initiator: RV32 byte loads/stores -> word transactions, sub-word stores by read-modify-write.
// Optional wait-abort after TIMEOUT_CYCLES when MEM_TIMEOUT_EN is defined.
module mem_request_initiator #(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  input  logic              mem_op_r
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_WAIT, MERGE, WR_WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic              op_r_q;
  logic              done;
  logic              timeout;
  logic              req_bad;

  logic              r_we, r_we_nxt;
  logic              r_uns, r_uns_nxt;
  logic [1:0]        r_size, r_size_nxt;
  logic [1:0]        r_off, r_off_nxt;
  logic [15:0]       r_wdata, r_wdata_nxt;
  logic [31:0]       rd_word, rd_word_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              mem_we_nxt;
  logic [31:0]       mem_data_in_nxt;
  logic [31:0]       rdata_nxt;
  logic              err_nxt;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    case (sz)
      SZ_B:    load_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    load_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [15:0] d);
    store_merge = w;
    if (sz == SZ_B) store_merge[8*off +: 8] = d[7:0];
    else            store_merge[16*off[1] +: 16] = d;
  endfunction

  // A level held high on mem_op_r must complete only one transaction.
  assign done       = mem_op_r & ~op_r_q;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign req_bad    = (req_size == 2'b11) ||
                      ((req_size == SZ_H) && req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));

`ifdef MEM_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (state == RD_WAIT || state == WR_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (state == RD_WAIT || state == WR_WAIT) && (wait_cnt == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_r_q      <= 1'b0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= 2'b00;
      r_off       <= 2'b00;
      r_wdata     <= '0;
      rd_word     <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_data_in <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      op_r_q      <= mem_op_r;
      r_we        <= r_we_nxt;
      r_uns       <= r_uns_nxt;
      r_size      <= r_size_nxt;
      r_off       <= r_off_nxt;
      r_wdata     <= r_wdata_nxt;
      rd_word     <= rd_word_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_we      <= mem_we_nxt;
      mem_data_in <= mem_data_in_nxt;
      resp_rdata  <= rdata_nxt;
      resp_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    r_we_nxt        = r_we;
    r_uns_nxt       = r_uns;
    r_size_nxt      = r_size;
    r_off_nxt       = r_off;
    r_wdata_nxt     = r_wdata;
    rd_word_nxt     = rd_word;
    mem_addr_nxt    = mem_addr;
    mem_we_nxt      = mem_we;
    mem_data_in_nxt = mem_data_in;
    rdata_nxt       = resp_rdata;
    err_nxt         = resp_err;

    case (state)
      IDLE: begin
        if (req_valid) begin
          r_we_nxt    = req_we;
          r_uns_nxt   = req_unsigned;
          r_size_nxt  = req_size;
          r_off_nxt   = req_addr[1:0];
          r_wdata_nxt = req_wdata[15:0];
          rdata_nxt   = '0;
          err_nxt     = req_bad;
          if (req_bad) begin
            state_nxt = RESP;
          end else begin
            mem_addr_nxt = req_addr[ADDR_W+1:2];
            if (req_we && req_size == SZ_W) begin
              mem_data_in_nxt = req_wdata;
              mem_we_nxt      = 1'b1;
              state_nxt       = WR_WAIT;
            end else begin
              mem_we_nxt = 1'b0;
              state_nxt  = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (done) begin
          if (r_we) begin
            rd_word_nxt = mem_data_out;
            state_nxt   = MERGE;
          end else begin
            rdata_nxt = load_extract(mem_data_out, r_size, r_uns, r_off);
            state_nxt = RESP;
          end
        end else if (timeout) begin
          err_nxt   = 1'b1;
          rdata_nxt = '0;
          state_nxt = RESP;
        end
      end
      MERGE: begin
        mem_data_in_nxt = store_merge(rd_word, r_size, r_off, r_wdata);
        mem_we_nxt      = 1'b1;
        state_nxt       = WR_WAIT;
      end
      WR_WAIT: begin
        if (done) begin
          mem_we_nxt = 1'b0;
          state_nxt  = RESP;
        end else if (timeout) begin
          mem_we_nxt = 1'b0;
          err_nxt    = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_request_initiator.sv
// Bench for mem_request_initiator: controller model on a 16-word memory plus a response scoreboard.
module tb_mem_request_initiator;
  localparam int AW = 24;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_data_in;
  logic [31:0]   mem_data_out = '0;
  logic          mem_op_r;

  mem_request_initiator #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_op_r(mem_op_r)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          resp_cnt = 0;
  logic        ctrl_auto = 1'b1;
  logic        auto_op_r = 1'b0;
  logic        man_op_r = 1'b0;
  logic        we_seen = 1'b0;
  logic        exp_to = 1'b0;
  int          ctrl_cnt = 0;
  int          ctrl_lat = 0;
  time         t_drive = 0;
  time         t_resp = 0;
  logic [31:0] last_wr = '0;

  assign mem_op_r = ctrl_auto ? auto_op_r : man_op_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  // Reference behaviour of one request; updates the shadow memory for stores.
  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [5:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] w;
    logic [31:0] sh;
    logic [31:0] mask;
    w      = ref_mem[a[5:2]];
    e.err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.rdata = '0;
    if (!e.err) begin
      if (!we) begin
        sh = w >> (a[1:0] * 8);
        if (sz == 2'b00)      e.rdata = uns ? (sh & 32'hFF)   : (sh[7]  ? (sh | 32'hFFFF_FF00) : (sh & 32'hFF));
        else if (sz == 2'b01) e.rdata = uns ? (sh & 32'hFFFF) : (sh[15] ? (sh | 32'hFFFF_0000) : (sh & 32'hFFFF));
        else                  e.rdata = w;
      end else begin
        if (sz == 2'b10) begin
          w = wd;
        end else begin
          mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
          w = (w & ~(mask << (a[1:0] * 8))) | ((wd & mask) << (a[1:0] * 8));
        end
        ref_mem[a[5:2]] = w;
      end
    end
    return e;
  endfunction

  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [5:0] a, input logic [31:0] wd);
    int   n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = '0;
    req_addr[5:0] = a;
    req_wdata    = wd;
    t_drive      = $time;
    if (exp_to) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else begin
      e = model(we, sz, uns, a, wd);
    end
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_addr  = '0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  // Controller model and response monitor, both sampling on the falling edge.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_we) we_seen = 1'b1;
      if (resp_valid) begin
        resp_cnt++;
        t_resp = $time;
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        end
      end
      mem_data_out = mem[mem_addr[3:0]];
      if (auto_op_r) begin
        auto_op_r = 1'b0;
      end else if (ctrl_auto && !req_ready && !rst) begin
        if (ctrl_cnt >= ctrl_lat) begin
          auto_op_r = 1'b1;
          ctrl_cnt  = 0;
          ctrl_lat  = $urandom_range(0, 3);
          if (mem_we) begin
            mem[mem_addr[3:0]] = mem_data_in;
            last_wr = mem_data_in;
          end
        end else begin
          ctrl_cnt++;
        end
      end
    end
  endtask

  initial begin
    logic [AW-1:0] a0;
    int            rc0;
    logic [5:0]    ea [3];
    logic [1:0]    es [3];
    logic          ew [3];

    fork
      monitor_loop();
      begin
        #400000;
        $display("FAIL watchdog: got no end of run, want completion before 400000");
        $fatal(1, "watchdog expired");
      end
    join_none

    for (int i = 0; i < 16; i++) set_word(i, 32'h5A00_0000 + 32'(i) * 32'h0001_0203);
    repeat (3) @(negedge clk);

    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data_in", mem_data_in, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    set_word(4, 32'hF0F0_F0F0);
    send(1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
    check("lw_mem_addr", 32'(mem_addr), 32'd4);
    check("lw_mem_we", {31'b0, mem_we}, 32'd0);
    drain("lw_drain");

    set_word(4, 32'h1234_8056);
    send(1'b0, 2'b00, 1'b0, 6'h11, 32'h0);
    drain("lb_drain");
    send(1'b0, 2'b00, 1'b1, 6'h11, 32'h0);
    drain("lbu_drain");

    set_word(4, 32'h1122_3344);
    send(1'b1, 2'b00, 1'b0, 6'h12, 32'h0000_00AB);
    check("sb_rd_phase_we", {31'b0, mem_we}, 32'd0);
    drain("sb_drain");
    check("sb_write_data", last_wr, 32'h11AB_3344);
    check("sb_mem_word", mem[4], 32'h11AB_3344);

    ea = '{6'h13, 6'h06, 6'h08};
    es = '{2'b01, 2'b10, 2'b11};
    ew = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      we_seen = 1'b0;
      a0 = mem_addr;
      send(ew[i], es[i], 1'b0, ea[i], 32'hDEAD_BEEF);
      drain("err_drain");
      check("err_no_write", {31'b0, we_seen}, 32'd0);
      check("err_mem_addr", 32'(mem_addr), 32'(a0));
      check("err_latency", 32'((t_resp - t_drive) / 10 + 1), 32'd2);
    end

    ctrl_auto = 1'b0;
    man_op_r  = 1'b0;
    set_word(8, 32'hCAFE_BABE);
    rc0 = resp_cnt;
    send(1'b0, 2'b10, 1'b0, 6'h20, 32'h0);
    @(negedge clk);
    man_op_r = 1'b1;
    repeat (3) @(negedge clk);
    man_op_r = 1'b0;
    repeat (4) @(negedge clk);
    check("held_high_resp_count", 32'(resp_cnt - rc0), 32'd1);
    drain("held_drain");

    send(1'b1, 2'b10, 1'b0, 6'h24, ref_mem[9]);
    check("wr_wait_we", {31'b0, mem_we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_we", {31'b0, mem_we}, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_no_resp", {31'b0, resp_valid}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    exp_to = 1'b1;
    send(1'b0, 2'b10, 1'b0, 6'h00, 32'h0);
    exp_to = 1'b0;
    drain("timeout_drain");
    check("timeout_latency", 32'((t_resp - t_drive) / 10 + 1), 32'(TO + 2));
`endif

    ctrl_auto = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("rand_drain");
    for (int i = 0; i < 16; i++) check("rand_mem_word", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
